// File: rtl/frame_loader_4k_pkg.sv
// Shared constants and FSM encoding for the 64x64, 12 bpp panel frame loader.
package frame_loader_4k_pkg;

    localparam int unsigned NUM_COLS    = 64;
    localparam int unsigned NUM_ROWS    = 64;
    localparam int unsigned HALF_SCREEN = NUM_COLS * NUM_ROWS / 2;
    localparam int unsigned BIT_DEPTH   = 12;
    localparam logic [7:0]  SYNC_BYTE   = 8'hA5;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/frame_loader_4k_if.sv
// Byte-stream input and frame-memory write/status bundle of the frame loader.
interface frame_loader_4k_if #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DATA_W = 24
) ();

    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              wr_en;
    logic              wr_bank;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              disp_bank;
    logic              busy;
    logic              frame_done;
    logic              error;

    modport master (
        output rx_data, rx_valid,
        input  wr_en, wr_bank, wr_addr, wr_data, disp_bank, busy, frame_done, error
    );

    modport slave (
        input  rx_data, rx_valid,
        output wr_en, wr_bank, wr_addr, wr_data, disp_bank, busy, frame_done, error
    );

endinterface

// File: rtl/frame_loader_4k_byte_packer.sv
// Packs three consecutive bytes into one 24-bit word {b0, b1, b2}; the word
// and its strobe are registered, so they appear the cycle after the third byte.
module byte_packer_3to1 (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_valid,
    input  logic [7:0]  i_data,
    output logic        o_word_valid,
    output logic [23:0] o_word
);

    logic [1:0]  r_phase;
    logic [7:0]  r_b0;
    logic [7:0]  r_b1;
    logic        r_word_valid;
    logic [23:0] r_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase      <= 2'd0;
            r_b0         <= 8'd0;
            r_b1         <= 8'd0;
            r_word_valid <= 1'b0;
            r_word       <= 24'd0;
        end else begin
            r_word_valid <= 1'b0;
            if (i_clear) begin
                r_phase <= 2'd0;
            end else if (i_valid) begin
                case (r_phase)
                    2'd0: begin
                        r_b0    <= i_data;
                        r_phase <= 2'd1;
                    end
                    2'd1: begin
                        r_b1    <= i_data;
                        r_phase <= 2'd2;
                    end
                    default: begin
                        r_word       <= {r_b0, r_b1, i_data};
                        r_word_valid <= 1'b1;
                        r_phase      <= 2'd0;
                    end
                endcase
            end
        end
    end

    assign o_word_valid = r_word_valid;
    assign o_word       = r_word;

endmodule

// File: rtl/frame_loader_4k.sv
// Sync-framed byte stream -> double-buffered frame memory writer; flips the
// display bank once a full frame of NUM_WORDS words has been written.
module frame_loader_4k
    import frame_loader_4k_pkg::*;
#(
    parameter int unsigned NUM_WORDS = HALF_SCREEN,
    parameter int unsigned ADDR_W    = 11,
    parameter int unsigned DATA_W    = 24,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int unsigned TIMEOUT   = 500000,
    parameter int unsigned TO_W      = 20
) (
    input logic               clk,
    input logic               rst,
    frame_loader_4k_if.slave  bus
);

    state_e            r_state;
    state_e            w_state_next;
    logic [ADDR_W-1:0] r_addr;
    logic [TO_W-1:0]   r_to;
    logic              r_disp_bank;
    logic              r_error;

    logic              w_sync;
    logic              w_load_byte;
    logic              w_expire;
    logic              w_last_write;
    logic              w_word_valid;
    logic [DATA_W-1:0] w_word;

    assign w_sync       = bus.rx_valid && (r_state == StIdle) && (bus.rx_data == SYNC_BYTE);
    assign w_load_byte  = bus.rx_valid && (r_state == StLoad);
    // A byte landing on the expiry cycle wins over the timeout.
    assign w_expire     = (r_state == StLoad) && !bus.rx_valid &&
                          (r_to == TO_W'(TIMEOUT - 1));
    assign w_last_write = w_word_valid && (r_addr == ADDR_W'(NUM_WORDS - 1));

    byte_packer_3to1 u_packer (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (w_sync),
        .i_valid      (w_load_byte),
        .i_data       (bus.rx_data),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: if (w_sync) w_state_next = StLoad;
            StLoad: begin
                if (w_last_write) begin
                    w_state_next = StDone;
                end else if (w_expire) begin
                    w_state_next = StIdle;
                end
            end
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_addr      <= '0;
            r_to        <= '0;
            r_disp_bank <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_error <= w_expire;
            if (w_sync) begin
                r_addr <= '0;
                r_to   <= '0;
            end else if (r_state == StLoad) begin
                if (bus.rx_valid) begin
                    r_to <= '0;
                end else if (!w_expire) begin
                    r_to <= r_to + TO_W'(1);
                end
                if (w_word_valid) begin
                    r_addr <= r_addr + ADDR_W'(1);
                end
            end
            if (r_state == StDone) begin
                r_disp_bank <= ~r_disp_bank;
            end
        end
    end

    assign bus.wr_en      = w_word_valid;
    assign bus.wr_bank    = ~r_disp_bank;
    assign bus.wr_addr    = r_addr;
    assign bus.wr_data    = w_word;
    assign bus.disp_bank  = r_disp_bank;
    assign bus.busy       = (r_state == StLoad);
    assign bus.frame_done = (r_state == StDone);
    assign bus.error      = r_error;

endmodule

// File: tb/tb_frame_loader_4k.sv
// Self-checking bench for frame_loader_4k: expected writes are queued as bytes
// are driven and compared when wr_en fires.
module tb_frame_loader_4k;

    localparam int unsigned NW  = 2048;
    localparam int unsigned AW  = 11;
    localparam int unsigned DW  = 24;
    localparam int unsigned TMO = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    frame_loader_4k_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    frame_loader_4k #(
        .NUM_WORDS (NW),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .SYNC_BYTE (8'hA5),
        .TIMEOUT   (TMO),
        .TO_W      (20)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned n_vec   = 0;
    int unsigned n_bad   = 0;
    int unsigned n_wr    = 0;
    int unsigned n_done  = 0;
    int unsigned n_err   = 0;
    logic [35:0] exp_q[$];
    logic        m_disp  = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Write monitor and pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.wr_en) begin
            n_wr++;
            if (exp_q.size() == 0) begin
                check("spurious_write", {28'd0, bus.wr_bank, bus.wr_addr, bus.wr_data},
                      64'hDEAD_0000_0000_0000);
            end else begin
                check("write", {28'd0, bus.wr_bank, bus.wr_addr, bus.wr_data},
                      {28'd0, exp_q.pop_front()});
            end
        end
        if (bus.frame_done) n_done++;
        if (bus.error) n_err++;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic put_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_wr_en"},      bus.wr_en,      0);
        check({tag, "_wr_addr"},    bus.wr_addr,    0);
        check({tag, "_wr_data"},    bus.wr_data,    0);
        check({tag, "_disp_bank"},  bus.disp_bank,  0);
        check({tag, "_wr_bank"},    bus.wr_bank,    1);
        check({tag, "_busy"},       bus.busy,       0);
        check({tag, "_frame_done"}, bus.frame_done, 0);
        check({tag, "_error"},      bus.error,      0);
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 20 && !bus.frame_done; i++) begin
            @(posedge clk);
            #1;
        end
        check(tag, bus.frame_done, 1);
    endtask

    task automatic load_frame(input string tag);
        int unsigned d0;
        int unsigned w0;
        logic [23:0] w;
        d0 = n_done;
        w0 = n_wr;
        put_byte(8'hA5);
        check({tag, "_busy"}, bus.busy, 1);
        for (int k = 0; k < NW; k++) begin
            w = {k[11:0], ~k[11:0]};
            put_byte(w[23:16]);
            put_byte(w[15:8]);
            exp_q.push_back({~m_disp, AW'(k), w});
            put_byte(w[7:0]);
        end
        wait_done({tag, "_frame_done"});
        idle(1);
        m_disp = ~m_disp;
        check({tag, "_disp_bank"}, bus.disp_bank, m_disp);
        check({tag, "_busy_after"}, bus.busy, 0);
        check({tag, "_writes"}, n_wr - w0, NW);
        check({tag, "_done_pulses"}, n_done - d0, 1);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        int unsigned w0;
        int unsigned e0;

        rst          = 1'b1;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        idle(3);
        rst = 1'b0;
        check_reset_state("reset");

        // Full frame into bank 1.
        load_frame("frame1");

        // Bytes before sync are ignored, then a single word.
        w0 = n_wr;
        put_byte(8'h11);
        put_byte(8'h22);
        check("presync_busy", bus.busy, 0);
        check("presync_writes", n_wr - w0, 0);
        put_byte(8'hA5);
        put_byte(8'h12);
        put_byte(8'h34);
        exp_q.push_back({~m_disp, AW'(0), 24'h123456});
        put_byte(8'h56);
        check("word_wr_en", bus.wr_en, 1);
        check("word_wr_addr", bus.wr_addr, 0);
        check("word_wr_data", bus.wr_data, 24'h123456);

        // Stall after 5 bytes: one error, back to IDLE, bank unchanged.
        e0 = n_err;
        put_byte(8'h78);
        put_byte(8'h9A);
        idle(TMO + 4);
        check("timeout_errors", n_err - e0, 1);
        check("timeout_busy", bus.busy, 0);
        check("timeout_disp_bank", bus.disp_bank, m_disp);
        check("timeout_writes", n_wr - w0, 1);

        // Byte exactly on the expiry cycle is taken, no error.
        e0 = n_err;
        w0 = n_wr;
        put_byte(8'hA5);
        put_byte(8'h01);
        put_byte(8'h02);
        exp_q.push_back({~m_disp, AW'(0), 24'h010203});
        put_byte(8'h03);
        put_byte(8'h04);
        idle(TMO - 1);
        put_byte(8'h05);
        check("expiry_busy", bus.busy, 1);
        check("expiry_error", bus.error, 0);
        exp_q.push_back({~m_disp, AW'(1), 24'h040506});
        put_byte(8'h06);
        idle(2);
        check("expiry_writes", n_wr - w0, 2);
        check("expiry_no_error", n_err - e0, 0);
        check("expiry_queue_empty", exp_q.size(), 0);
        idle(TMO + 4);
        check("expiry_later_timeout", n_err - e0, 1);

        // Two full frames back to back after a reset.
        rst = 1'b1;
        idle(2);
        rst    = 1'b0;
        m_disp = 1'b0;
        check_reset_state("reset2");
        w0 = n_wr;
        load_frame("frame2a");
        load_frame("frame2b");
        check("two_frames_writes", n_wr - w0, 2 * NW);

        // Reset mid-frame at byte 3000, then a clean frame.
        put_byte(8'hA5);
        for (int k = 0; k < 1000; k++) begin
            logic [23:0] w;
            w = {k[11:0], ~k[11:0]};
            put_byte(w[23:16]);
            put_byte(w[15:8]);
            exp_q.push_back({~m_disp, AW'(k), w});
            put_byte(w[7:0]);
        end
        rst = 1'b1;
        idle(2);
        rst    = 1'b0;
        m_disp = 1'b0;
        check_reset_state("midframe_reset");
        check("midframe_queue_empty", exp_q.size(), 0);
        load_frame("frame3");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
